// File: rtl/irq_ctrl.sv
// Interrupt controller: rising-edge capture into pending bits, masking, fixed
// lowest-index-first arbitration, and a held request until the core acks.
module irq_ctrl #(
    parameter int          N_SRC      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0040
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    output logic             irq,
    output logic [31:0]      irq_addr,
    input  logic             irq_ack,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [31:0]      cfg_wd,
    output logic [31:0]      cfg_rd
);

    // Handshake: irq stays high from arbitration until a one-cycle irq_ack
    // pulse; irq_ack is only honoured while a request is being presented.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] prev_q;
    logic [N_SRC-1:0] rise, eligible;
    logic [2:0]       active_id_q, active_id_d, winner;
    logic [31:0]      irq_addr_q, irq_addr_d, win_vec;
    logic [31:0]      vec_q [N_SRC];
    logic [31:0]      vec_d [N_SRC];
    logic             win_found;

    assign rise     = irq_src & ~prev_q;
    assign eligible = pending_q & mask_q;
    assign irq      = (state_q == ASSERT);
    assign irq_addr = irq_addr_q;

    always_comb begin
        winner    = 3'd0;
        win_vec   = vec_q[0];
        win_found = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!win_found && eligible[i]) begin
                win_found = 1'b1;
                winner    = 3'(i);
                win_vec   = vec_q[i];
            end
        end
    end

    // Clears are applied before new edges so a coincident rise keeps the bit.
    always_comb begin
        mask_d    = mask_q;
        pending_d = pending_q;
        vec_d     = vec_q;
        if (cfg_we && cfg_addr == 4'd0) mask_d = cfg_wd[N_SRC-1:0];
        if (cfg_we && cfg_addr == 4'd1) pending_d = pending_d & ~cfg_wd[N_SRC-1:0];
        if (state_q == ASSERT && irq_ack) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (active_id_q == 3'(i)) pending_d[i] = 1'b0;
            end
        end
        pending_d = pending_d | rise;
        for (int i = 0; i < N_SRC; i++) begin
            if (cfg_we && cfg_addr == 4'(8 + i)) vec_d[i] = cfg_wd;
        end
    end

    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        irq_addr_d  = irq_addr_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = ASSERT;
                    active_id_d = winner;
                    irq_addr_d  = win_vec;
                end
            end
            ASSERT: begin
                if (irq_ack) state_d = HOLDOFF;
            end
            HOLDOFF: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_rd = 32'd0;
        case (cfg_addr)
            4'd0: cfg_rd[N_SRC-1:0] = mask_q;
            4'd1: cfg_rd[N_SRC-1:0] = pending_q;
            4'd2: cfg_rd = {25'd0, active_id_q, 3'd0, irq};
            default: begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (cfg_addr == 4'(8 + i)) cfg_rd = vec_q[i];
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            pending_q   <= '0;
            prev_q      <= '0;
            active_id_q <= 3'd0;
            irq_addr_q  <= 32'd0;
            for (int i = 0; i < N_SRC; i++) begin
                vec_q[i] <= VEC_BASE + VEC_STRIDE * 32'(i);
            end
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            pending_q   <= pending_d;
            prev_q      <= irq_src;
            active_id_q <= active_id_d;
            irq_addr_q  <= irq_addr_d;
            vec_q       <= vec_d;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: behavioural request model checked every cycle, an
// expected-address queue per presented request, and directed literal checks.
module tb_irq_ctrl;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] irq_src = '0;
  logic         irq;
  logic [31:0]  irq_addr;
  logic         irq_ack = 1'b0;
  logic         cfg_we = 1'b0;
  logic [3:0]   cfg_addr = 4'd0;
  logic [31:0]  cfg_wd = 32'd0;
  logic [31:0]  cfg_rd;

  int n_pass  = 0;
  int n_total = 0;

  irq_ctrl #(.N_SRC(N), .VEC_BASE(32'h0), .VEC_STRIDE(32'h40)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .irq(irq), .irq_addr(irq_addr),
    .irq_ack(irq_ack), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wd(cfg_wd),
    .cfg_rd(cfg_rd)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model: outstanding request flag, quiet cycles after an ack, arrays per source
  bit          m_pend [N];
  bit          m_mask [N];
  bit          m_prev [N];
  logic [31:0] m_vec  [N];
  bit          m_irq;
  int          m_quiet;
  int          m_active;
  logic [31:0] m_addr;
  bit          nxt_pend [N];
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [31:0] model_rd(input logic [3:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a == 4'd0) for (int i = 0; i < N; i++) r[i] = m_mask[i];
    if (a == 4'd1) for (int i = 0; i < N; i++) r[i] = m_pend[i];
    if (a == 4'd2) r = 32'(m_irq) + 32'(m_active) * 16;
    if (int'(a) >= 8 && int'(a) < 8 + N) r = m_vec[int'(a) - 8];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_mask[i] = 0; m_prev[i] = 0;
        m_vec[i]  = 32'(i * 64);
      end
      m_irq = 0; m_quiet = 0; m_active = 0; m_addr = 32'd0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        nxt_pend[i] = m_pend[i];
        if (cfg_we && cfg_addr == 4'd1 && cfg_wd[i]) nxt_pend[i] = 0;
      end
      if (m_irq && irq_ack) nxt_pend[m_active] = 0;
      for (int i = 0; i < N; i++) if (irq_src[i] && !m_prev[i]) nxt_pend[i] = 1;
      if (m_irq) begin
        if (irq_ack) begin m_irq = 0; m_quiet = 1; end
      end else if (m_quiet > 0) begin
        m_quiet--;
      end else begin
        for (int i = N - 1; i >= 0; i--) begin
          if (m_pend[i] && m_mask[i]) begin m_irq = 1; m_active = i; end
        end
        if (m_irq) begin m_addr = m_vec[m_active]; exp_q.push_back(m_addr); end
      end
      if (cfg_we && cfg_addr == 4'd0) for (int i = 0; i < N; i++) m_mask[i] = cfg_wd[i];
      if (cfg_we && int'(cfg_addr) >= 8 && int'(cfg_addr) < 8 + N) m_vec[int'(cfg_addr) - 8] = cfg_wd;
      for (int i = 0; i < N; i++) begin m_pend[i] = nxt_pend[i]; m_prev[i] = irq_src[i]; end
    end
  end

  // scoreboard / per-cycle compare
  logic last_irq = 1'b0;
  initial begin
    wait (rst === 1'b1);
    forever begin
      @(negedge clk);
      check("irq", {31'd0, irq}, {31'd0, m_irq});
      check("irq_addr", irq_addr, m_addr);
      check("cfg_rd", cfg_rd, model_rd(cfg_addr));
      if (irq && !last_irq) begin
        if (exp_q.size() == 0) check("exp_q_underflow", 32'd1, 32'd0);
        else check("req_addr", irq_addr, exp_q.pop_front());
      end
      last_irq = irq;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wd = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_src(input logic [N-1:0] s);
    irq_src = s;
    step();
    irq_src = '0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    cfg_addr = a; #1;
    check(name, cfg_rd, exp);
  endtask

  initial begin
    #1 rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_addr", irq_addr, 32'd0);
    rd_check("rst_vec2", 4'd10, 32'h80);
    rd_check("rst_mask", 4'd0, 32'h0);

    // 1: single source, upper mask bits read 0
    cfg_write(4'd0, 32'hFFFF_FFF5);
    rd_check("mask_rd", 4'd0, 32'h5);
    cfg_write(4'd5, 32'hDEAD_BEEF);
    rd_check("unmapped5", 4'd5, 32'h0);
    pulse_src(4'b0100);
    rd_check("t1_pend", 4'd1, 32'h4);
    check("t1_irq_early", {31'd0, irq}, 32'd0);
    step();
    check("t1_irq", {31'd0, irq}, 32'd1);
    check("t1_addr", irq_addr, 32'h80);
    rd_check("t1_status", 4'd2, 32'h21);
    do_ack();
    check("t1_ack_irq", {31'd0, irq}, 32'd0);
    step(); step();

    // 2: two sources same cycle, lowest wins, two low cycles then the other
    pulse_src(4'b0101);
    rd_check("t2_pend", 4'd1, 32'h5);
    step();
    check("t2_addr0", irq_addr, 32'h0);
    do_ack();
    check("t2_hold_irq", {31'd0, irq}, 32'd0);
    rd_check("t2_pend_clr", 4'd1, 32'h4);
    step();
    check("t2_idle_irq", {31'd0, irq}, 32'd0);
    step();
    check("t2_irq2", {31'd0, irq}, 32'd1);
    check("t2_addr2", irq_addr, 32'h80);
    do_ack(); step(); step();

    // 3: masked pending, unmask, W1C before ack
    cfg_write(4'd0, 32'h0);
    pulse_src(4'b0010);
    step();
    check("t3_masked_irq", {31'd0, irq}, 32'd0);
    rd_check("t3_pend", 4'd1, 32'h2);
    cfg_write(4'd0, 32'h2);
    check("t3_irq_wait", {31'd0, irq}, 32'd0);
    step();
    check("t3_irq", {31'd0, irq}, 32'd1);
    check("t3_addr", irq_addr, 32'h40);
    cfg_write(4'd1, 32'h2);
    rd_check("t3_w1c", 4'd1, 32'h0);
    step();
    check("t3_held", {31'd0, irq}, 32'd1);
    do_ack(); step(); step();

    // 4: vector rewrite, no preemption
    cfg_write(4'd11, 32'h0000_1234);
    cfg_write(4'd0, 32'h8);
    pulse_src(4'b1000);
    step();
    check("t4_addr", irq_addr, 32'h1234);
    cfg_write(4'd11, 32'h0000_FFFF);
    check("t4_frozen", irq_addr, 32'h1234);
    rd_check("t4_vec3", 4'd11, 32'hFFFF);
    cfg_write(4'd0, 32'h9);
    pulse_src(4'b0001);
    step();
    check("t4_nopreempt", irq_addr, 32'h1234);
    do_ack(); step(); step();
    check("t4_reassert", {31'd0, irq}, 32'd1);
    check("t4_addr0", irq_addr, 32'h0);
    do_ack(); step(); step();

    // 5: held level gives one pending; edge coincident with ack-clear survives
    cfg_write(4'd0, 32'h2);
    irq_src = 4'b0010;
    step(); step(); step();
    check("t5_irq", {31'd0, irq}, 32'd1);
    do_ack();
    repeat (6) step();
    check("t5_no_rereq", {31'd0, irq}, 32'd0);
    rd_check("t5_pend0", 4'd1, 32'h0);
    irq_src = '0;
    step();
    pulse_src(4'b0010);
    step();
    irq_src = 4'b0010; irq_ack = 1'b1;
    step();
    irq_src = '0; irq_ack = 1'b0;
    rd_check("t5_setwins", 4'd1, 32'h2);
    step(); step();
    check("t5_again", {31'd0, irq}, 32'd1);
    check("t5_again_addr", irq_addr, 32'h40);
    do_ack(); step(); step();

    // 6: ack in IDLE ignored; async reset mid-request
    cfg_write(4'd0, 32'h0);
    pulse_src(4'b0001);
    do_ack();
    rd_check("t6_idle_ack", 4'd1, 32'h1);
    cfg_write(4'd8, 32'h5555);
    cfg_write(4'd0, 32'h1);
    step();
    check("t6_addr", irq_addr, 32'h5555);
    cfg_addr = 4'd1;
    rst = 1'b1;
    #1;
    check("t6_rst_irq", {31'd0, irq}, 32'd0);
    check("t6_rst_pend", cfg_rd, 32'd0);
    rd_check("t6_rst_vec0", 4'd8, 32'h0);
    rd_check("t6_rst_vec1", 4'd9, 32'h40);
    step();
    rst = 1'b0;
    step(); step();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
